// File: rtl/regbank_scan_reader.sv
// Self-test read-back engine: walks every register address through the bank's
// single-outstanding read handshake and checks each word against SEED + address.
module regbank_scan_reader #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 5,
  parameter logic [31:0] SEED       = 32'hA5A5_0000,
  parameter int          TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  rd_req,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_valid,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH:0]   err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic                  timeout
);

  localparam int                    TMR_W     = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0]      TMR_LAST  = TMR_W'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [DATA_WIDTH-1:0] SEED_W    = DATA_WIDTH'(SEED);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t                  state_q;
  logic                    rd_req_q;
  logic [ADDR_WIDTH-1:0]   rd_addr_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    pass_q;
  logic [ADDR_WIDTH:0]     err_count_q;
  logic [ADDR_WIDTH:0]     err_count_d;
  logic [ADDR_WIDTH-1:0]   first_err_q;
  logic                    timeout_q;
  logic [TMR_W-1:0]        timer_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    mismatch;

  function automatic logic [DATA_WIDTH-1:0] expected_word(input logic [ADDR_WIDTH-1:0] a);
    return SEED_W + DATA_WIDTH'(a);
  endfunction

  assign mismatch    = (data_q != expected_word(rd_addr_q));
  assign err_count_d = err_count_q + (ADDR_WIDTH + 1)'(mismatch);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= '0;
      first_err_q <= '0;
      timeout_q   <= 1'b0;
      timer_q     <= '0;
    end else begin
      rd_req_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q     <= S_REQ;
            rd_req_q    <= 1'b1;
            busy_q      <= 1'b1;
            rd_addr_q   <= '0;
            err_count_q <= '0;
            first_err_q <= '0;
            timeout_q   <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
          end
        end
        S_REQ: begin
          timer_q <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // A response on the final permitted WAIT cycle still wins over the timeout.
          if (rd_valid) begin
            state_q <= S_CHECK;
          end else if (timer_q == TMR_LAST) begin
            state_q   <= S_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
            pass_q    <= 1'b0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_CHECK: begin
          if (mismatch) begin
            if (err_count_q == '0) first_err_q <= rd_addr_q;
            err_count_q <= err_count_d;
          end
          if (rd_addr_q == LAST_ADDR) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_count_d == '0);
          end else begin
            rd_addr_q <= rd_addr_q + 1'b1;
            state_q   <= S_REQ;
            rd_req_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Read data is only ever consumed in CHECK, so the capture register needs no reset.
  always_ff @(posedge clk) begin
    if (state_q == S_WAIT && rd_valid) data_q <= rd_data;
  end

  assign rd_req         = rd_req_q;
  assign rd_addr        = rd_addr_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_q;
  assign timeout        = timeout_q;

endmodule

// File: tb/tb_regbank_scan_reader.sv
// Directed-sequence bench for regbank_scan_reader with a randomized-latency bank
// responder and a reference model of the expected scan outcome.
module tb_regbank_scan_reader;

  localparam int          DW   = 32;
  localparam int          AW   = 5;
  localparam int          N    = 1 << AW;
  localparam int          TMO  = 15;
  localparam logic [31:0] SEED = 32'hA5A5_0000;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;
  logic          pass;
  logic [AW:0]   err_count;
  logic [AW-1:0] first_err_addr;
  logic          timeout;

  logic [DW-1:0] bank [N];
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  regbank_scan_reader #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .SEED      (SEED),
    .TIMEOUT   (TMO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .first_err_addr(first_err_addr),
    .timeout       (timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pattern(input int a);
    return SEED + DW'(a);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_bank();
    for (int a = 0; a < N; a++) bank[a] = pattern(a);
  endtask

  // Pulses start, then plays the bank: answers each rd_req after a random latency
  // in [lmin,lmax], never answers address 'stall', and returns early at 'abort_at'.
  task automatic run_scan(input int lmin, input int lmax, input int stall, input int abort_at,
                          input bit spurious, input bit poke_start,
                          output int n_req, output int done_cyc, output int exp_done);
    int s, sum, cnt, cur, lat;
    n_req = 0; done_cyc = -1; exp_done = -1; sum = 0; cnt = 0; cur = 0;
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      start    = poke_start && (k == 40);
      rd_valid = 1'b0;
      rd_data  = $urandom;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (rd_req) begin
        check("rd_addr_seq", rd_addr, n_req);
        check("busy_in_scan", busy, 1);
        if (abort_at >= 0 && int'(rd_addr) == abort_at) begin
          start = 1'b0;
          return;
        end
        cur = int'(rd_addr);
        n_req++;
        lat = $urandom_range(lmax, lmin);
        cnt = lat;
        sum += lat + 2;
        if (cur == stall) exp_done = cyc + TMO + 1;
        if (spurious) begin
          rd_valid = 1'b1;
          rd_data  = ~bank[cur];
        end
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0 && cur != stall) begin
          rd_valid = 1'b1;
          rd_data  = bank[cur];
        end
      end
      tick();
    end
    start    = 1'b0;
    rd_valid = 1'b0;
    if (stall < 0) exp_done = s + 1 + sum;
    check("done_reached", done, 1);
  endtask

  task automatic check_result(input int stall, input int n_req, input int done_cyc, input int exp_done);
    int last, exp_err, exp_first;
    last = (stall >= 0) ? stall - 1 : N - 1;
    exp_err = 0;
    exp_first = 0;
    for (int a = 0; a <= last; a++) begin
      if (bank[a] !== pattern(a)) begin
        if (exp_err == 0) exp_first = a;
        exp_err++;
      end
    end
    check("done_time", done_cyc, exp_done);
    check("req_count", n_req, (stall >= 0) ? stall + 1 : N);
    check("busy_at_done", busy, 0);
    check("timeout", timeout, stall >= 0);
    check("pass", pass, (stall < 0) && (exp_err == 0));
    check("err_count", err_count, exp_err);
    check("first_err_addr", first_err_addr, exp_first);
    check("final_rd_addr", rd_addr, (stall >= 0) ? stall : N - 1);
  endtask

  initial begin
    int nr, dc, ed;
    reset    = 1'b1;
    start    = 1'b0;
    rd_valid = 1'b0;
    rd_data  = '0;
    fill_bank();
    tick();
    tick();
    check("reset_outs", {rd_req, rd_addr, busy, done, pass, err_count, first_err_addr, timeout}, 0);
    reset = 1'b0;
    tick();
    check("idle_outs", {rd_req, rd_addr, busy, done, pass, err_count, first_err_addr, timeout}, 0);

    // Clean scan, latency 1: done 97 cycles after start.
    run_scan(1, 1, -1, -1, 1'b0, 1'b0, nr, dc, ed);
    check_result(-1, nr, dc, ed);

    // Single corrupted word at address 7.
    bank[7] = bank[7] ^ 32'h1;
    run_scan(1, 1, -1, -1, 1'b0, 1'b0, nr, dc, ed);
    check_result(-1, nr, dc, ed);
    fill_bank();

    // Two corruptions, random latency, bogus rd_valid in every rd_req cycle.
    bank[20] = bank[20] ^ $urandom_range(32'hFFFF, 1);
    bank[3]  = bank[3] ^ 32'h8000_0000;
    run_scan(1, TMO, -1, -1, 1'b1, 1'b0, nr, dc, ed);
    check_result(-1, nr, dc, ed);
    fill_bank();

    // Maximum permitted latency must not time out.
    run_scan(TMO, TMO, -1, -1, 1'b0, 1'b0, nr, dc, ed);
    check_result(-1, nr, dc, ed);

    // Responder stalls at address 5.
    run_scan(1, 3, 5, -1, 1'b0, 1'b0, nr, dc, ed);
    check_result(5, nr, dc, ed);

    // Reset mid-scan at address 10 with an error already logged, then stale rd_valid.
    bank[3] = bank[3] ^ 32'h1;
    run_scan(1, 1, -1, 10, 1'b0, 1'b0, nr, dc, ed);
    check("abort_addr", rd_addr, 10);
    check("abort_err_logged", err_count, 1);
    reset    = 1'b1;
    rd_valid = 1'b1;
    rd_data  = pattern(10);
    tick();
    check("midscan_reset_outs", {rd_req, rd_addr, busy, done, pass, err_count, first_err_addr, timeout}, 0);
    rd_valid = 1'b0;
    tick();
    reset    = 1'b0;
    rd_valid = 1'b1;
    tick();
    rd_valid = 1'b0;
    tick();
    check("idle_after_stale", {rd_req, rd_addr, busy, done, pass, err_count, first_err_addr, timeout}, 0);
    fill_bank();
    run_scan(1, 4, -1, -1, 1'b0, 1'b0, nr, dc, ed);
    check_result(-1, nr, dc, ed);

    // rd_valid while in DONE, then a scan with start re-pulsed mid-scan.
    rd_valid = 1'b1;
    rd_data  = 32'h0;
    tick();
    rd_valid = 1'b0;
    check("done_hold", {done, pass, busy}, 3'b110);
    bank[31] = bank[31] + 32'h1;
    run_scan(1, 2, -1, -1, 1'b0, 1'b1, nr, dc, ed);
    check_result(-1, nr, dc, ed);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
